// File: rtl/mul_arbiter_tt.sv
// mul_arbiter_tt: two-requester round-robin scheduler in front of one shared,
// taint-tracked sequential multiplier.
//
// A job is granted in IDLE, its operands are latched, the multiplier is
// started with a one-cycle pulse, the block waits for the multiplier's level
// done signal to drop (leaving the previous result) and rise again, then the
// product is returned to the owner with a one-cycle strobe.
// Every data/control output carries a 1-bit taint built by OR-propagation.
//
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   reqN / reqN_t                level request from requester N and its taint
//   aN, aN_t / bN, bN_t          operands (multiplier / multiplicand) + taints
//   gntN / gntN_t                requester N owns the multiplier
//   rsp_valid0/1, rsp_valid_t    one-cycle result strobe to the owner + taint
//   rsp_data / rsp_data_t        registered product + taint
//   busy                         FSM not in IDLE
//   mul_start / mul_start_t      start pulse to the multiplier + taint
//   mul_multiplier(_t)           latched operand a + taint
//   mul_multiplicand(_t)         latched operand b + taint
//   mul_product(_t)              product from the multiplier + taint
//   mul_done / mul_done_t        multiplier product-done level + taint
module mul_arbiter_tt #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req0_t,
  input  logic [WIDTH-1:0]   a0,
  input  logic               a0_t,
  input  logic [WIDTH-1:0]   b0,
  input  logic               b0_t,
  input  logic               req1,
  input  logic               req1_t,
  input  logic [WIDTH-1:0]   a1,
  input  logic               a1_t,
  input  logic [WIDTH-1:0]   b1,
  input  logic               b1_t,
  output logic               gnt0,
  output logic               gnt0_t,
  output logic               gnt1,
  output logic               gnt1_t,
  output logic               rsp_valid0,
  output logic               rsp_valid1,
  output logic               rsp_valid_t,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_data_t,
  output logic               busy,
  output logic               mul_start,
  output logic               mul_start_t,
  output logic [WIDTH-1:0]   mul_multiplier,
  output logic               mul_multiplier_t,
  output logic [WIDTH-1:0]   mul_multiplicand,
  output logic               mul_multiplicand_t,
  input  logic [2*WIDTH-1:0] mul_product,
  input  logic               mul_product_t,
  input  logic               mul_done,
  input  logic               mul_done_t
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_LO = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               ptr_q, ptr_d;         // preferred requester on a tie
  logic               owner_q, owner_d;     // requester of the current job
  logic               arb_t_q, arb_t_d;     // taint of the arbitration decision
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic               op_a_t_q, op_a_t_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               op_b_t_q, op_b_t_d;
  logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_data_t_q, rsp_data_t_d;
  logic               done_t_q, done_t_d;   // taint of the done that ended the job

  // Requester 1 wins when it is the only one asking, or on a tie when the
  // round-robin pointer favours it.
  logic pick1;
  assign pick1 = req1 && (!req0 || ptr_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    arb_t_d      = arb_t_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    op_a_d       = op_a_q;
    op_a_t_d     = op_a_t_q;
    op_b_d       = op_b_q;
    op_b_t_d     = op_b_t_q;
    rsp_data_d   = rsp_data_q;
    rsp_data_t_d = rsp_data_t_q;
    done_t_d     = done_t_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d  = pick1;
          gnt0_d   = !pick1;
          gnt1_d   = pick1;
          // Whether the losing request was tainted still influences who won.
          arb_t_d  = (req0 & req0_t) | (req1 & req1_t);
          op_a_d   = pick1 ? a1   : a0;
          op_a_t_d = pick1 ? a1_t : a0_t;
          op_b_d   = pick1 ? b1   : b0;
          op_b_t_d = pick1 ? b1_t : b0_t;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_LO;
      // done is a level from the previous job; wait until it drops so the
      // stale product is never returned.
      WAIT_LO: if (!mul_done) state_d = WAIT_HI;
      WAIT_HI: begin
        if (mul_done) begin
          rsp_data_d   = mul_product;
          rsp_data_t_d = mul_product_t | mul_done_t | arb_t_q;
          done_t_d     = mul_done_t;
          state_d      = RESP;
        end
      end
      RESP: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = !owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      arb_t_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      op_a_q       <= '0;
      op_a_t_q     <= 1'b0;
      op_b_q       <= '0;
      op_b_t_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_data_t_q <= 1'b0;
      done_t_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      arb_t_q      <= arb_t_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      op_a_q       <= op_a_d;
      op_a_t_q     <= op_a_t_d;
      op_b_q       <= op_b_d;
      op_b_t_q     <= op_b_t_d;
      rsp_data_q   <= rsp_data_d;
      rsp_data_t_q <= rsp_data_t_d;
      done_t_q     <= done_t_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt0_t      = gnt0_q & arb_t_q;
  assign gnt1        = gnt1_q;
  assign gnt1_t      = gnt1_q & arb_t_q;
  assign rsp_valid0  = (state_q == RESP) & !owner_q;
  assign rsp_valid1  = (state_q == RESP) & owner_q;
  assign rsp_valid_t = (state_q == RESP) & (arb_t_q | done_t_q);
  assign rsp_data    = rsp_data_q;
  assign rsp_data_t  = rsp_data_t_q;
  assign busy        = (state_q != IDLE);
  assign mul_start   = (state_q == ISSUE);
  assign mul_start_t = (state_q == ISSUE) & arb_t_q;

  assign mul_multiplier     = op_a_q;
  assign mul_multiplier_t   = op_a_t_q;
  assign mul_multiplicand   = op_b_q;
  assign mul_multiplicand_t = op_b_t_q;

endmodule

// File: tb/tb_mul_arbiter_tt.sv
// Self-checking bench for mul_arbiter_tt: a table of single-job vectors plus
// hand-written sequences for reset mid-job, fairness and a stale done level.
// A small behavioural multiplier runs on the falling edge.
module tb_mul_arbiter_tt;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 0, req0_t = 0, a0_t = 0, b0_t = 0;
  logic         req1 = 0, req1_t = 0, a1_t = 0, b1_t = 0;
  logic [63:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt0_t, gnt1, gnt1_t;
  logic         rsp_valid0, rsp_valid1, rsp_valid_t;
  logic [127:0] rsp_data;
  logic         rsp_data_t, busy, mul_start, mul_start_t;
  logic [63:0]  mul_multiplier, mul_multiplicand;
  logic         mul_multiplier_t, mul_multiplicand_t;
  logic [127:0] mul_product = '0;
  logic         mul_product_t = 0, mul_done = 0, mul_done_t = 0;

  always #5 clk = ~clk;

  mul_arbiter_tt #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_t(req0_t), .a0(a0), .a0_t(a0_t), .b0(b0), .b0_t(b0_t),
    .req1(req1), .req1_t(req1_t), .a1(a1), .a1_t(a1_t), .b1(b1), .b1_t(b1_t),
    .gnt0(gnt0), .gnt0_t(gnt0_t), .gnt1(gnt1), .gnt1_t(gnt1_t),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1), .rsp_valid_t(rsp_valid_t),
    .rsp_data(rsp_data), .rsp_data_t(rsp_data_t), .busy(busy),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
    .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t)
  );

  // Behavioural multiplier: done is a level that stays high after a job.
  // stale_cfg keeps the old done high for that many cycles after a start;
  // hang stops the job from ever completing.
  int          stale_cfg = 0;
  bit          hang = 0;
  int          stale_left = 0;
  int          cnt = -1;
  logic [63:0] pa, pb;
  logic        pt;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mul_done = 0; cnt = -1; stale_left = 0;
      end else if (mul_start) begin
        pa = mul_multiplier; pb = mul_multiplicand;
        pt = mul_multiplier_t | mul_multiplicand_t | mul_start_t;
        cnt = 3;
        stale_left = stale_cfg;
        if (stale_cfg == 0) mul_done = 0;
      end else if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) mul_done = 0;
      end else if (cnt > 0 && !hang) begin
        cnt--;
        if (cnt == 0) begin
          mul_product   = {64'd0, pa} * {64'd0, pb};
          mul_product_t = pt;
          mul_done      = 1;
        end
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        req0, req0_t;
    logic [63:0] a0;
    logic        a0_t;
    logic [63:0] b0;
    logic        b0_t;
    logic        req1, req1_t;
    logic [63:0] a1;
    logic        a1_t;
    logic [63:0] b1;
    logic        b1_t;
    logic        done_t;
    logic        exp_owner, exp_arb_t;
    logic [127:0] exp_data;
    logic        exp_data_t, exp_valid_t, exp_mplier_t, exp_mcand_t;
  } vec_t;

  task automatic wait_gnt(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin ok = 1; break; end
    end
    if (!ok) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid0 || rsp_valid1) begin ok = 1; break; end
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  // One complete job: request, grant, start pulse, response, back to idle.
  task automatic run_vec(input vec_t v);
    bit ok;
    logic [63:0] own_a;
    own_a = v.exp_owner ? v.a1 : v.a0;
    @(negedge clk);
    req0 = v.req0; req0_t = v.req0_t; a0 = v.a0; a0_t = v.a0_t; b0 = v.b0; b0_t = v.b0_t;
    req1 = v.req1; req1_t = v.req1_t; a1 = v.a1; a1_t = v.a1_t; b1 = v.b1; b1_t = v.b1_t;
    mul_done_t = v.done_t;
    wait_gnt(ok);
    if (!ok) return;
    check("gnt_owner", {gnt1, gnt0}, v.exp_owner ? 2'b10 : 2'b01);
    check("gnt_t", {gnt1_t, gnt0_t}, v.exp_arb_t ? (v.exp_owner ? 2'b10 : 2'b01) : 2'b00);
    // Operands are only guaranteed until grant; scramble them afterwards.
    req0 = 0; req1 = 0; a0 = '1; b0 = '1; a1 = '1; b1 = '1;
    a0_t = 1; b0_t = 1; a1_t = 1; b1_t = 1;
    check("mul_start", mul_start, 1);
    check("mul_start_t", mul_start_t, v.exp_arb_t);
    check("mplier", mul_multiplier, own_a);
    check("mplier_t", mul_multiplier_t, v.exp_mplier_t);
    check("mcand_t", mul_multiplicand_t, v.exp_mcand_t);
    @(negedge clk);
    check("start_pulse", mul_start, 0);
    wait_rsp(ok);
    if (!ok) return;
    check("rsp_owner", {rsp_valid1, rsp_valid0}, v.exp_owner ? 2'b10 : 2'b01);
    check("rsp_data", rsp_data, v.exp_data);
    check("rsp_data_t", rsp_data_t, v.exp_data_t);
    check("rsp_valid_t", rsp_valid_t, v.exp_valid_t);
    check("gnt_in_resp", {gnt1, gnt0}, v.exp_owner ? 2'b10 : 2'b01);
    check("mplier_held", mul_multiplier, own_a);
    @(negedge clk);
    check("idle_after", {busy, rsp_valid1, rsp_valid0, gnt1, gnt0}, 0);
    mul_done_t = 0; a0_t = 0; b0_t = 0; a1_t = 0; b1_t = 0;
  endtask

  vec_t vecs[8];
  vec_t vx;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int seen;
    //                 r0 t  a0           at b0     bt  r1 t  a1      at b1       bt  dt  own arb data                            dt vt mt ct
    vecs[0] = '{1,0,64'd3,0,64'd5,0,        0,0,64'd0,0,64'd0,0,   0, 0,0,128'd15,0,0,0,0};
    vecs[1] = '{0,0,64'd0,0,64'd0,0,        1,0,64'd6,0,64'd7,1,   0, 1,0,128'd42,1,0,0,1};
    vecs[2] = '{1,1,64'd10,0,64'd11,0,      1,0,64'd1,0,64'd1,0,   0, 0,1,128'd110,1,1,0,0};
    vecs[3] = '{1,1,64'd2,0,64'd2,0,        1,0,64'd4,0,64'd9,0,   0, 1,1,128'd36,1,1,0,0};
    vecs[4] = '{1,0,64'hFFFF_FFFF_FFFF_FFFF,0,64'd2,0, 1,0,64'd5,1,64'd5,1, 0, 0,0,128'h1_FFFF_FFFF_FFFF_FFFE,0,0,0,0};
    vecs[5] = '{1,0,64'd7,1,64'd9,0,        0,0,64'd0,0,64'd0,0,   0, 0,0,128'd63,1,0,1,0};
    vecs[6] = '{0,0,64'd0,0,64'd0,0,        1,1,64'd0,0,64'd123,0, 0, 1,1,128'd0,1,1,0,0};
    vecs[7] = '{1,0,64'd7,0,64'd8,0,        0,0,64'd0,0,64'd0,0,   1, 0,0,128'd56,1,1,0,0};

    repeat (3) @(negedge clk);
    check("reset_state", {busy, gnt0, gnt1, mul_start, rsp_valid0, rsp_valid1, rsp_data_t}, 0);
    check("reset_data", rsp_data, 0);
    rst = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the job sits in WAIT_HI with a multiplier that never finishes.
    hang = 1;
    @(negedge clk);
    req0 = 1; a0 = 64'd3; b0 = 64'd3;
    wait_gnt(ok);
    req0 = 0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 0;
    #1;
    check("rst_ctrl", {gnt0, gnt0_t, gnt1, gnt1_t, busy, mul_start, mul_start_t,
                       rsp_valid0, rsp_valid1, rsp_valid_t, rsp_data_t,
                       mul_multiplier_t, mul_multiplicand_t}, 0);
    check("rst_data", rsp_data, 0);
    check("rst_ops", {mul_multiplier, mul_multiplicand}, 0);
    @(negedge clk);
    rst = 1; hang = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid0 || rsp_valid1 || busy) seen++;
    end
    check("no_rsp_after_rst", seen, 0);

    // Both held high: grants alternate 0,1,0 starting from the reset pointer.
    @(negedge clk);
    req0 = 1; a0 = 64'd2; b0 = 64'd7;
    req1 = 1; a1 = 64'd4; b1 = 64'd9;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(ok);
      if (!ok) break;
      check("fair_onehot", gnt0 & gnt1, 0);
      check("fair_owner", {gnt1, gnt0}, (k == 1) ? 2'b10 : 2'b01);
      wait_rsp(ok);
      if (!ok) break;
      check("fair_rsp_owner", {rsp_valid1, rsp_valid0}, (k == 1) ? 2'b10 : 2'b01);
      check("fair_data", rsp_data, (k == 1) ? 128'd36 : 128'd14);
    end
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);

    // A plain req1 job after the reset.
    vx = '{0,0,64'd0,0,64'd0,0, 1,0,64'd11,0,64'd3,0, 0, 1,0,128'd33,0,0,0,0};
    run_vec(vx);

    // Done still high from the previous job when the new one issues.
    stale_cfg = 3;
    vx = '{1,0,64'd5,0,64'd6,0, 0,0,64'd0,0,64'd0,0, 0, 0,0,128'd30,0,0,0,0};
    run_vec(vx);
    stale_cfg = 0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
